cgra_linebuf_tile: RTL and testbench

- Single CGRA memory tile configured as a programmable-depth line buffer (delay line).
- 16-bit data arrives on the tile's BUS16 input track, write strobe on its BUS1 input track.
- Once the buffer holds `depth` words, each new write pops the oldest word to the output track with a valid flag.
- Configured through the global CGRA config bus, addressed by tile ID.

---
 rtl/cgra_linebuf_pkg.sv | 23 ++
 rtl/linebuf_sram.sv | 39 +++
 rtl/cgra_linebuf_tile.sv | 185 ++++++++++++++++++
 tb/tb_cgra_linebuf_tile.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_linebuf_pkg.sv
// Shared constants for the CGRA line-buffer tile: config address field
// positions, the memory feature code, register indices and data width.
package cgra_linebuf_pkg;

   localparam int DATA_W = 16;

   // Feature code selecting the memory tile's register file
   localparam logic [7:0] FEATURE_MEM = 8'h08;

   // Register indices carried in config_addr[31:24]
   localparam logic [7:0] REG_CTRL  = 8'd0;
   localparam logic [7:0] REG_DEPTH = 8'd1;
   localparam logic [7:0] REG_AF    = 8'd2;

   // Config address field slices
   localparam int CFG_TILE_LSB = 0;
   localparam int CFG_TILE_MSB = 15;
   localparam int CFG_FEAT_LSB = 16;
   localparam int CFG_FEAT_MSB = 23;
   localparam int CFG_REG_LSB  = 24;
   localparam int CFG_REG_MSB  = 31;

endpackage

// File: rtl/linebuf_sram.sv
// 1R1W synchronous memory for the line buffer. A read and a write to the
// same address in the same cycle return the word stored before the write.
module linebuf_sram #(
   parameter int MEM_DEPTH = 1024,
   parameter int AW        = 10,
   parameter int DW        = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [MEM_DEPTH];
   logic [DW-1:0] rdata_q;

   // Storage array write port
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; non-blocking update keeps old data on collision
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cgra_linebuf_tile.sv
// CGRA memory tile acting as a programmable-depth line buffer. Words written
// on the BUS16 track emerge `depth` writes later on the output track.
// Optional macro LB_ALMOST_FULL_EN adds the AF_THRESH register and the
// almost_full output; without it almost_full is constant 0.
module cgra_linebuf_tile
   import cgra_linebuf_pkg::*;
#(
   parameter logic [15:0] TILE_ID   = 16'h0001,
   parameter int          MEM_DEPTH = 1024,
   parameter int          AW        = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       config_addr,
   input  logic [31:0]       config_data,
   input  logic [DATA_W-1:0] wire_m1_2_BUS16_S1_T0,
   input  logic              wire_m1_2_BUS1_S1_T0,
   output logic [DATA_W-1:0] out_BUS16_S0_T0,
   output logic              out_BUS1_S0_T0,
   output logic              out_BUS1_S1_T0,
   output logic [31:0]       read_data
);

   localparam logic [AW:0] DEPTH_MAX = (AW+1)'(MEM_DEPTH);

   // Configuration registers
   logic          enable_q, enable_d;
   logic [AW:0]   depth_q, depth_d;
`ifdef LB_ALMOST_FULL_EN
   logic [AW:0]   af_thresh_q, af_thresh_d;
`endif
   logic [31:0]   read_data_q, read_data_d;

   // Buffer state
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;

   // Output state
   logic [DATA_W-1:0] byp_data_q;
   logic              out_sel_byp_q;
   logic              valid_q;
   logic              almost_full_q;

   logic              cfg_hit_s;
   logic [7:0]        cfg_reg_s;
   logic              ptr_clear_s;
   logic              wr_en_s, bypass_s, push_s, pop_s, af_s;
   logic [DATA_W-1:0] sram_rdata_s;

   assign cfg_hit_s = (config_addr[CFG_TILE_MSB:CFG_TILE_LSB] == TILE_ID) &&
                      (config_addr[CFG_FEAT_MSB:CFG_FEAT_LSB] == FEATURE_MEM);
   assign cfg_reg_s = config_addr[CFG_REG_MSB:CFG_REG_LSB];

   // Config register next-state, buffer-clear request and readback value
   always_comb begin
      enable_d    = enable_q;
      depth_d     = depth_q;
`ifdef LB_ALMOST_FULL_EN
      af_thresh_d = af_thresh_q;
`endif
      read_data_d = 32'h0000_0000;
      ptr_clear_s = 1'b0;
      if (cfg_hit_s) begin
         case (cfg_reg_s)
            REG_CTRL: begin
               enable_d    = config_data[0];
               ptr_clear_s = ~config_data[0];
               read_data_d = {31'd0, config_data[0]};
            end
            REG_DEPTH: begin
               depth_d     = (config_data > 32'(MEM_DEPTH)) ? DEPTH_MAX : config_data[AW:0];
               ptr_clear_s = 1'b1;
               read_data_d = {{(31-AW){1'b0}}, depth_d};
            end
`ifdef LB_ALMOST_FULL_EN
            REG_AF: begin
               af_thresh_d = config_data[AW:0];
               read_data_d = {{(31-AW){1'b0}}, config_data[AW:0]};
            end
`endif
            default: begin
               read_data_d = 32'h0000_0000;
            end
         endcase
      end else begin
         read_data_d = 32'h0000_0000;
      end
   end

   assign wr_en_s  = enable_q && wire_m1_2_BUS1_S1_T0;
   assign bypass_s = wr_en_s && (depth_q == '0);
   assign push_s   = wr_en_s && (depth_q != '0);
   assign pop_s    = push_s && (count_q == depth_q);

   // Pointer and occupancy next-state; a config clear overrides traffic
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (ptr_clear_s) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else if (push_s) begin
            count_d = count_q + (AW+1)'(1);
         end else begin
            count_d = count_q;
         end
      end
   end

`ifdef LB_ALMOST_FULL_EN
   assign af_s = enable_q && (count_q >= af_thresh_q);
`else
   assign af_s = 1'b0;
`endif

   // State update with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         enable_q      <= 1'b0;
         depth_q       <= '0;
`ifdef LB_ALMOST_FULL_EN
         af_thresh_q   <= '0;
`endif
         read_data_q   <= 32'h0000_0000;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         byp_data_q    <= '0;
         out_sel_byp_q <= 1'b0;
         valid_q       <= 1'b0;
         almost_full_q <= 1'b0;
      end else begin
         enable_q      <= enable_d;
         depth_q       <= depth_d;
`ifdef LB_ALMOST_FULL_EN
         af_thresh_q   <= af_thresh_d;
`endif
         read_data_q   <= read_data_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         valid_q       <= bypass_s | pop_s;
         almost_full_q <= af_s;
         if (bypass_s) begin
            byp_data_q    <= wire_m1_2_BUS16_S1_T0;
            out_sel_byp_q <= 1'b1;
         end else if (pop_s) begin
            out_sel_byp_q <= 1'b0;
         end
      end
   end

   linebuf_sram #(
      .MEM_DEPTH (MEM_DEPTH),
      .AW        (AW),
      .DW        (DATA_W)
   ) u_sram (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (push_s),
      .waddr_i (wr_ptr_q),
      .wdata_i (wire_m1_2_BUS16_S1_T0),
      .re_i    (pop_s),
      .raddr_i (rd_ptr_q),
      .rdata_o (sram_rdata_s)
   );

   // Output word comes from whichever path produced the most recent value
   assign out_BUS16_S0_T0 = out_sel_byp_q ? byp_data_q : sram_rdata_s;
   assign out_BUS1_S0_T0  = valid_q;
   assign out_BUS1_S1_T0  = almost_full_q;
   assign read_data       = read_data_q;

endmodule

// File: tb/tb_cgra_linebuf_tile.sv
// Self-checking bench for cgra_linebuf_tile: a constant vector table for
// reset/config, hand sequences for the depth-512 fill/pop and bypass cases,
// then randomized traffic against a queue-based reference model.
module tb_cgra_linebuf_tile;

`ifdef LB_ALMOST_FULL_EN
   localparam bit AF_ON = 1'b1;
`else
   localparam bit AF_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] config_addr, config_data;
   logic [15:0] din;
   logic        wen;
   logic [15:0] dout;
   logic        valid, afull;
   logic [31:0] read_data;

   int n_checks = 0;
   int n_errors = 0;

   cgra_linebuf_tile dut (
      .clk                   (clk),
      .reset                 (reset),
      .config_addr           (config_addr),
      .config_data           (config_data),
      .wire_m1_2_BUS16_S1_T0 (din),
      .wire_m1_2_BUS1_S1_T0  (wen),
      .out_BUS16_S0_T0       (dout),
      .out_BUS1_S0_T0        (valid),
      .out_BUS1_S1_T0        (afull),
      .read_data             (read_data)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (delay line as a queue) -------------
   logic        m_en;
   int          m_depth;
   int          m_af;
   logic [15:0] m_q[$];
   logic [15:0] m_dout;
   logic        m_valid, m_afo;
   logic [31:0] m_rd;

   task automatic model_step(input logic rst, input logic [31:0] ca, input logic [31:0] cd,
                             input logic [15:0] d, input logic w);
      logic af_next;
      if (!rst) begin
         m_en = 1'b0; m_depth = 0; m_af = 0; m_q.delete();
         m_dout = 16'h0; m_valid = 1'b0; m_afo = 1'b0; m_rd = 32'h0;
      end else begin
         af_next = AF_ON && m_en && (m_q.size() >= m_af);
         m_valid = 1'b0;
         if (m_en && w) begin
            if (m_depth == 0) begin
               m_dout = d; m_valid = 1'b1;
            end else begin
               m_q.push_back(d);
               if (m_q.size() > m_depth) begin
                  m_dout = m_q.pop_front(); m_valid = 1'b1;
               end
            end
         end
         m_rd = 32'h0;
         if (ca[15:0] == 16'h0001 && ca[23:16] == 8'h08) begin
            case (ca[31:24])
               8'd0: begin
                  m_en = cd[0];
                  if (!cd[0]) m_q.delete();
                  m_rd = {31'd0, cd[0]};
               end
               8'd1: begin
                  m_depth = (cd > 32'd1024) ? 1024 : int'(cd);
                  m_q.delete();
                  m_rd = 32'(m_depth);
               end
               8'd2: begin
                  if (AF_ON) begin
                     m_af = int'(cd[10:0]);
                     m_rd = {21'd0, cd[10:0]};
                  end
               end
               default: m_rd = 32'h0;
            endcase
         end
         m_afo = af_next;
      end
   endtask

   // ---------------- helpers ---------------------------------------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic rst, input logic [31:0] ca, input logic [31:0] cd,
                      input logic [15:0] d, input logic w);
      reset = rst; config_addr = ca; config_data = cd; din = d; wen = w;
      @(posedge clk);
      model_step(rst, ca, cd, d, w);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_dout"},  {16'h0, dout},     {16'h0, m_dout});
      chk({tag, "_valid"}, {31'h0, valid},    {31'h0, m_valid});
      chk({tag, "_af"},    {31'h0, afull},    {31'h0, m_afo});
      chk({tag, "_rd"},    read_data,         m_rd);
   endtask

   typedef struct {
      logic        rst;
      logic [31:0] ca;
      logic [31:0] cd;
      logic [15:0] d;
      logic        w;
      logic [15:0] e_dout;
      logic        e_valid;
      logic        e_af;
      logic [31:0] e_rd;
   } vec_t;

   function automatic vec_t mk(logic rst, logic [31:0] ca, logic [31:0] cd, logic [15:0] d,
                               logic w, logic [15:0] ed, logic ev, logic ea, logic [31:0] er);
      vec_t v;
      v.rst = rst; v.ca = ca; v.cd = cd; v.d = d; v.w = w;
      v.e_dout = ed; v.e_valid = ev; v.e_af = ea; v.e_rd = er;
      return v;
   endfunction

   vec_t vecs[19];

   initial begin
      logic [15:0] exp_d;
      logic [15:0] r_d;
      logic        r_w;
      logic [31:0] ca, cd;

      // reset held 8 cycles with config/traffic that must be ignored
      for (int i = 0; i < 8; i++)
         vecs[i] = mk(1'b0, (i < 4) ? 32'h0108_0001 : 32'h0008_0001, 32'h0000_0055,
                      16'hABCD, 1'b1, 16'h0, 1'b0, 1'b0, 32'h0);
      vecs[8]  = mk(1'b1, 32'h0, 32'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0);
      vecs[9]  = mk(1'b1, 32'h0008_0001, 32'h1, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h1);
      // depth still 0 after reset-time config -> bypass
      vecs[10] = mk(1'b1, 32'h0, 32'h0, 16'h1234, 1'b1, 16'h1234, 1'b1, AF_ON, 32'h0);
      vecs[11] = mk(1'b1, 32'h0108_0001, 32'h200, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON, 32'h200);
      vecs[12] = mk(1'b1, 32'h0108_0002, 32'h5, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON, 32'h0);
      vecs[13] = mk(1'b1, 32'h0107_0001, 32'h5, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON, 32'h0);
      vecs[14] = mk(1'b1, 32'h0108_0001, 32'h7FF, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON, 32'h400);
      vecs[15] = mk(1'b1, 32'h0108_0001, 32'h200, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON, 32'h200);
      vecs[16] = mk(1'b1, 32'h0308_0001, 32'h1, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON, 32'h0);
      vecs[17] = mk(1'b1, 32'h0208_0001, 32'd510, 16'h0, 1'b0, 16'h1234, 1'b0, AF_ON,
                    AF_ON ? 32'd510 : 32'h0);
      vecs[18] = mk(1'b1, 32'h0, 32'h0, 16'h0, 1'b0, 16'h1234, 1'b0, 1'b0, 32'h0);

      for (int i = 0; i < 19; i++) begin
         cyc(vecs[i].rst, vecs[i].ca, vecs[i].cd, vecs[i].d, vecs[i].w);
         chk($sformatf("vec%0d_dout", i),  {16'h0, dout},  {16'h0, vecs[i].e_dout});
         chk($sformatf("vec%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].e_valid});
         chk($sformatf("vec%0d_af", i),    {31'h0, afull}, {31'h0, vecs[i].e_af});
         chk($sformatf("vec%0d_rd", i),    read_data,      vecs[i].e_rd);
      end

      // depth 512: fill without output, almost_full after count reaches 510
      for (int i = 0; i < 512; i++) begin
         cyc(1'b1, 32'h0, 32'h0, 16'(i), 1'b1);
         chk("fill_valid", {31'h0, valid}, 32'h0);
         chk("fill_af", {31'h0, afull}, {31'h0, AF_ON && (i >= 510)});
      end
      cyc(1'b1, 32'h0, 32'h0, 16'd512, 1'b1);
      chk("pop0_dout", {16'h0, dout}, 32'd0);
      chk("pop0_valid", {31'h0, valid}, 32'h1);
      chk("pop0_af", {31'h0, afull}, {31'h0, AF_ON});
      cyc(1'b1, 32'h0, 32'h0, 16'd513, 1'b1);
      chk("pop1_dout", {16'h0, dout}, 32'd1);
      chk("pop1_valid", {31'h0, valid}, 32'h1);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 32'h0, 32'h0, 16'hDEAD, 1'b0);
         chk("gap_valid", {31'h0, valid}, 32'h0);
         chk("gap_dout_hold", {16'h0, dout}, 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 32'h0, 32'h0, 16'(514 + i), 1'b1);
         chk("resume_dout", {16'h0, dout}, 32'(2 + i));
         chk("resume_valid", {31'h0, valid}, 32'h1);
      end

      // depth 0 bypass
      cyc(1'b1, 32'h0108_0001, 32'h0, 16'h0, 1'b0);
      chk("depth0_rd", read_data, 32'h0);
      exp_d = 16'd4;
      for (int i = 0; i < 12; i++) begin
         r_d = 16'($urandom);
         r_w = (i % 3) != 1;
         cyc(1'b1, 32'h0, 32'h0, r_d, r_w);
         if (r_w) exp_d = r_d;
         chk("byp_valid", {31'h0, valid}, {31'h0, r_w});
         chk("byp_dout", {16'h0, dout}, {16'h0, exp_d});
      end

      // full-memory depth: read/write collision must return old data
      cyc(1'b1, 32'h0108_0001, 32'h800, 16'h0, 1'b0);
      chk_model("clamp");
      for (int i = 0; i < 1030; i++) begin
         cyc(1'b1, 32'h0, 32'h0, 16'($urandom), 1'b1);
         chk_model("full");
      end

      // randomized traffic and reconfiguration against the model
      for (int i = 0; i < 4000; i++) begin
         ca = 32'h0; cd = 32'h0;
         if ($urandom_range(15) == 0) begin
            ca = {8'($urandom_range(3)), 8'h08, 16'h0001};
            if ($urandom_range(7) == 0) ca[15:0] = 16'h0002;
            case (ca[31:24])
               8'd0:    cd = {$urandom_range(1) == 0 ? 31'h0 : 31'($urandom), $urandom_range(4) != 0};
               8'd1:    cd = 32'($urandom_range(24));
               8'd2:    cd = 32'($urandom_range(30));
               default: cd = $urandom;
            endcase
         end
         cyc(1'b1, ca, cd, 16'($urandom), $urandom_range(3) != 0);
         chk_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
